// File: rtl/button_event_decoder.sv
// Button gesture classifier: turns a debounced level into 1-cycle
// press/release/short/long/double (and optional auto-repeat) pulses.
//
// Ports:
//   clk           system clock, all logic on posedge
//   reset_n       asynchronous active-low reset
//   btn_db        debounced, clk-synchronous button level (1 = pressed)
//   press_pulse   1-cycle pulse on every accepted press
//   release_pulse 1-cycle pulse on every accepted release
//   short_pulse   single click with no second press within DBL_TICKS
//   long_pulse    button held LONG_TICKS cycles
//   double_pulse  second press within DBL_TICKS of a short release
//   repeat_pulse  auto-repeat while long-held (0 when compiled out)
//   busy          registered, high whenever the FSM is not idle
//
// Optional feature: define BTN_AUTOREPEAT_EN to enable auto-repeat.
module button_event_decoder #(
    parameter int CNT_W        = 26,
    parameter int LONG_TICKS   = 50_000_000,
    parameter int DBL_TICKS    = 30_000_000,
    parameter int REPEAT_TICKS = 10_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_db,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic double_pulse,
    output logic repeat_pulse,
    output logic busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESSED,
        S_LONG_HELD,
        S_WAIT_DBL,
        S_SECOND
    } state_t;

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] DBL_TC  = CNT_W'(DBL_TICKS - 1);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_TICKS - 1);
`endif

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             btn_q;
    logic             rise;
    logic             fall;

    logic press_d;
    logic release_d;
    logic short_d;
    logic long_d;
    logic double_d;
    logic busy_d;
`ifdef BTN_AUTOREPEAT_EN
    logic repeat_d;
`endif

    assign rise = btn_db & ~btn_q;
    assign fall = ~btn_db & btn_q;

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        double_d  = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        repeat_d  = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            S_PRESSED: begin
                // A release on the terminal-count cycle is still a click.
                if (fall) begin
                    state_d   = S_WAIT_DBL;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (cnt == LONG_TC) begin
                    state_d = S_LONG_HELD;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt + ONE;
                end
            end
            S_LONG_HELD: begin
                if (fall) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
`ifdef BTN_AUTOREPEAT_EN
                    if (cnt == REP_TC) begin
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        cnt_d = cnt + ONE;
                    end
`endif
                end
            end
            S_WAIT_DBL: begin
                // A re-press on the timeout cycle still counts as double.
                if (rise) begin
                    state_d  = S_SECOND;
                    cnt_d    = '0;
                    press_d  = 1'b1;
                    double_d = 1'b1;
                end else if (cnt == DBL_TC) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    short_d = 1'b1;
                end else begin
                    cnt_d = cnt + ONE;
                end
            end
            S_SECOND: begin
                if (fall) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // btn_q resets high so a button held through reset must be
    // released and pressed again before it generates any event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            btn_q         <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            double_pulse  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            btn_q         <= btn_db;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            short_pulse   <= short_d;
            long_pulse    <= long_d;
            double_pulse  <= double_d;
            busy          <= busy_d;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= repeat_d;
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule
